ddr2_axi_traffic_gen: RTL and testbench
=======================================

# ddr2_axi_traffic_gen

AXI4-Lite master that exercises `ddr2_axi_controller` from its slave port. On `start` it writes a deterministic pattern to `NUM_WORDS` consecutive word addresses, reads them back, and compares each word. It reports pass/fail, an error count and the first failing address. It sits in the test/bring-up subsystem and connects directly to the controller's S_AXI ports.

## Interface
- `ADDR_WIDTH`, 28, AXI address width; matches the controller.
- `DATA_WIDTH`, 32, AXI data width; a multiple of 8.
- `AXI_ID_WIDTH`, 4, ID width; AWID/ARID are driven to constant 0.
- `NUM_WORDS`, 256, number of words per run; must be ≥1.
- `BASE_ADDR`, 0, byte address of the first word; must be word aligned.
- `CMP_MASK`, all ones, bit mask applied to both RDATA and expected data before comparing.
- `TIMEOUT`, 1024, maximum cycles any single handshake may wait.
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  sticky; set at run end, cleared by the next accepted start.
- pass  out  1  valid while done; 1 when err_count==0 and no timeout.
- timeout  out  1  sticky; a handshake exceeded TIMEOUT.
- err_count  out  16  count of mismatches plus non-OKAY responses; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_WIDTH  address of the first error.
- M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R*  master-side ports mirroring the controller's S_AXI set; directions are inverted relative to that slave.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - On start, clear idx, err_count, first_err_addr, timeout and done.
  - Go to WR_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together.
  - AWADDR = BASE_ADDR + idx*(DATA_WIDTH/8).
  - WDATA = pattern(addr) = addr XOR 32'hA5A5_A5A5, truncated or zero-extended to DATA_WIDTH.
  - WSTRB is all ones.
  - Each valid drops the cycle after its own handshake. Per-channel done flags allow AW and W to complete in either order or in the same cycle.
  - When both have completed, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, if BRESP!=2'b00, count an error.
  - Then increment idx. If idx==NUM_WORDS-1, clear idx and go to RD_REQ; otherwise return to WR_REQ.
- RD_REQ:
  - ARVALID is asserted with the address computed the same way as AWADDR.
  - On ARREADY, go to RD_RESP.
- RD_RESP:
  - RREADY=1.
  - On RVALID, compare (RDATA & CMP_MASK) against (pattern(addr) & CMP_MASK). A mismatch or RRESP!=2'b00 counts as one error, not two.
  - Advance idx exactly as in WR_RESP; after the last word go to DONE.
- On any error, when err_count was 0, latch first_err_addr.
- Watchdog:
  - The counter resets on every state change.
  - If it reaches TIMEOUT in any of the four request/response states: set timeout, deassert all valids/readies, go to DONE.
- DONE: done=1, busy=0, then go to IDLE. done stays high until the next start.

## Timing
- Reset values: all valids/readies 0; busy, done, pass and timeout 0; err_count 0; first_err_addr 0; addresses and data 0. The FSM is in IDLE.
- All outputs are registered.
- AWVALID/WVALID rise the cycle after start is sampled.
- With a zero-wait slave, each write takes 2 cycles (request, response) and each read takes 2 cycles. The run completes 4*NUM_WORDS+1 cycles after start.
- A valid, once asserted, is held with stable payload until its handshake.
- start arriving in the same cycle as DONE→IDLE is not accepted; start is sampled only in IDLE.
- ARESETN asserted mid-run aborts immediately. Outputs return to reset values asynchronously, and no partial transaction is resumed.

## Structure
- Add to `ddr2_pkg`:
  - `tg_state_t` enum.
  - `AXI_RESP_OKAY` constant, 2'b00.
  - `tg_pattern(addr)` function.
- Single module; no sub-module. The watchdog and pattern logic are inline.

## Test plan
- Zero-wait responder model, NUM_WORDS=4, BASE_ADDR=0 -> writes to 0x0/0x4/0x8/0xC with WDATA 0xA5A5A5A5/A1/AD/A9; readback matches; done at cycle 17; pass=1; err_count=0.
- Slave accepts AW 3 cycles before W -> exactly one AW handshake and one W handshake per word; no duplicate write.
- Responder corrupts RDATA at addr 0x8 -> err_count=1, first_err_addr=0x8, pass=0.
- BRESP=2'b10 on the second write -> err_count=1, first_err_addr=0x4.
- ARREADY held low, TIMEOUT=16 -> timeout=1 after 16 cycles in RD_REQ, done=1, pass=0, ARVALID=0.
- ARESETN pulsed during WR_RESP -> all outputs return to 0; a new start completes a full passing run.

Source files
------------

// File: rtl/ddr2_pkg.sv
// Shared types and helpers for the DDR2 AXI subsystem (controller and bring-up logic).
package ddr2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } tg_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] TG_PATTERN_KEY = 32'hA5A5_A5A5;

    // Address-derived test word; every address gets a distinct value.
    function automatic logic [31:0] tg_pattern(input logic [31:0] addr);
        return addr ^ TG_PATTERN_KEY;
    endfunction

endpackage

// File: rtl/ddr2_axi_traffic_gen.sv
// AXI4-Lite bring-up master: writes an address pattern to NUM_WORDS words, reads it back,
// and reports pass/fail, error count, first failing address and handshake timeouts.
module ddr2_axi_traffic_gen
    import ddr2_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 28,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            AXI_ID_WIDTH = 4,
    parameter int unsigned            NUM_WORDS    = 256,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter logic [DATA_WIDTH-1:0]  CMP_MASK     = '1,
    parameter int unsigned            TIMEOUT      = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [15:0]               err_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr,

    output logic [AXI_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int unsigned       IdxW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned       WdW       = $clog2(TIMEOUT + 1);
    localparam int unsigned       ByteShift = $clog2(DATA_WIDTH / 8);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NUM_WORDS - 1);
    localparam logic [WdW-1:0]    WdLimit   = WdW'(TIMEOUT - 1);

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IdxW-1:0] i);
        return BASE_ADDR + (ADDR_WIDTH'(i) << ByteShift);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_data(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(tg_pattern(32'(a)));
    endfunction

    tg_state_t               state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d, idx_inc;
    logic [WdW-1:0]          wd_q, wd_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                    err_hit, in_wait;
    logic [ADDR_WIDTH-1:0]   err_addr;

    assign aw_hs   = awvalid_q & M_AXI_AWREADY;
    assign w_hs    = wvalid_q & M_AXI_WREADY;
    assign b_hs    = bready_q & M_AXI_BVALID;
    assign ar_hs   = arvalid_q & M_AXI_ARREADY;
    assign r_hs    = rready_q & M_AXI_RVALID;
    assign idx_inc = idx_q + IdxW'(1);
    assign in_wait = (state_q == StWrReq) || (state_q == StWrResp) ||
                     (state_q == StRdReq) || (state_q == StRdResp);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        err_hit     = 1'b0;
        err_addr    = awaddr_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StWrReq;
                    idx_d       = '0;
                    err_d       = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    awaddr_d    = word_addr('0);
                    wdata_d     = word_data(word_addr('0));
                end
            end
            StWrReq: begin
                // AW and W complete independently; move on once both have.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = StWrResp;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWrResp: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    err_hit  = (M_AXI_BRESP != AXI_RESP_OKAY);
                    err_addr = awaddr_q;
                    if (idx_q == LastIdx) begin
                        idx_d     = '0;
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                        araddr_d  = word_addr('0);
                    end else begin
                        idx_d     = idx_inc;
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = word_addr(idx_inc);
                        wdata_d   = word_data(word_addr(idx_inc));
                    end
                end
            end
            StRdReq: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    err_hit  = (M_AXI_RRESP != AXI_RESP_OKAY) ||
                               (((M_AXI_RDATA ^ word_data(araddr_q)) & CMP_MASK) != '0);
                    err_addr = araddr_q;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d     = idx_inc;
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                        araddr_d  = word_addr(idx_inc);
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0) && !timeout_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (err_hit) begin
            if (err_q == '0) first_err_d = err_addr;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        end

        // Watchdog: the current state has stalled for TIMEOUT cycles.
        if (in_wait && (state_d == state_q) && (wd_q == WdLimit)) begin
            timeout_d = 1'b1;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StDone;
        end

        wd_d = (state_d != state_q) ? '0 : wd_q + WdW'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wd_q        <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;
    assign M_AXI_AWID     = '0;
    assign M_AXI_AWADDR   = awaddr_q;
    assign M_AXI_AWVALID  = awvalid_q;
    assign M_AXI_WDATA    = wdata_q;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WVALID   = wvalid_q;
    assign M_AXI_BREADY   = bready_q;
    assign M_AXI_ARID     = '0;
    assign M_AXI_ARADDR   = araddr_q;
    assign M_AXI_ARVALID  = arvalid_q;
    assign M_AXI_RREADY   = rready_q;

endmodule

// File: tb/tb_ddr2_axi_traffic_gen.sv
// Directed bench for ddr2_axi_traffic_gen against a small configurable AXI4-Lite responder.
module tb_ddr2_axi_traffic_gen;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [27:0] first_err_addr;
    logic [3:0]  M_AXI_AWID, M_AXI_ARID;
    logic [27:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int vectors = 0;
    int miscompares = 0;

    // Responder knobs
    logic aw_allow = 1'b1;
    logic ar_allow = 1'b1;
    int   w_delay = 0;
    logic corrupt_en = 1'b0;
    logic bresp_err_en = 1'b0;

    always #5 ACLK = ~ACLK;

    ddr2_axi_traffic_gen #(
        .ADDR_WIDTH  (28),
        .DATA_WIDTH  (32),
        .AXI_ID_WIDTH(4),
        .NUM_WORDS   (4),
        .BASE_ADDR   (28'h0),
        .CMP_MASK    (32'hFFFF_FFFF),
        .TIMEOUT     (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .M_AXI_AWID    (M_AXI_AWID),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARID    (M_AXI_ARID),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    // Responder: AWREADY/ARREADY are level knobs, WREADY rises after w_delay stalled cycles.
    logic [31:0] mem [16];
    logic        have_aw, have_w;
    logic [27:0] aw_addr_l;
    logic [31:0] w_data_l;
    int          w_cnt;
    logic        got_aw, got_w;
    logic [27:0] cur_aw;
    logic [31:0] cur_w;

    assign M_AXI_AWREADY = aw_allow;
    assign M_AXI_ARREADY = ar_allow;
    assign M_AXI_WREADY  = (w_cnt >= w_delay);
    assign got_aw = have_aw | (M_AXI_AWVALID & M_AXI_AWREADY);
    assign got_w  = have_w | (M_AXI_WVALID & M_AXI_WREADY);
    assign cur_aw = (M_AXI_AWVALID & M_AXI_AWREADY) ? M_AXI_AWADDR : aw_addr_l;
    assign cur_w  = (M_AXI_WVALID & M_AXI_WREADY) ? M_AXI_WDATA : w_data_l;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            have_aw      <= 1'b0;
            have_w       <= 1'b0;
            aw_addr_l    <= '0;
            w_data_l     <= '0;
            w_cnt        <= 0;
            M_AXI_BVALID <= 1'b0;
            M_AXI_BRESP  <= 2'b00;
            M_AXI_RVALID <= 1'b0;
            M_AXI_RDATA  <= '0;
            M_AXI_RRESP  <= 2'b00;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                have_aw   <= 1'b1;
                aw_addr_l <= M_AXI_AWADDR;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                have_w   <= 1'b1;
                w_data_l <= M_AXI_WDATA;
                w_cnt    <= 0;
            end else if (M_AXI_WVALID) begin
                w_cnt <= w_cnt + 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (got_aw && got_w && !M_AXI_BVALID) begin
                mem[cur_aw[5:2]] <= cur_w;
                M_AXI_BVALID     <= 1'b1;
                M_AXI_BRESP      <= (bresp_err_en && cur_aw == 28'h4) ? 2'b10 : 2'b00;
                have_aw          <= 1'b0;
                have_w           <= 1'b0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                M_AXI_RRESP  <= 2'b00;
                M_AXI_RDATA  <= mem[M_AXI_ARADDR[5:2]] ^
                                ((corrupt_en && M_AXI_ARADDR == 28'h8) ? 32'h1 : 32'h0);
            end
        end
    end

    // Handshake log
    int          aw_count = 0;
    int          w_count = 0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];

    always @(posedge ACLK) begin
        if (ARESETN && M_AXI_AWVALID && M_AXI_AWREADY) begin
            wr_addr_log[aw_count % 64] <= 32'(M_AXI_AWADDR);
            aw_count <= aw_count + 1;
        end
        if (ARESETN && M_AXI_WVALID && M_AXI_WREADY) begin
            wr_data_log[w_count % 64] <= M_AXI_WDATA;
            w_count <= w_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns #1 after the edge that samples it.
    task automatic start_run();
        @(negedge ACLK);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge ACLK);
            #1;
            n++;
        end
    endtask

    int cycles;
    int aw_base, w_base;

    initial begin
        ARESETN = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_status", 32'({busy, done, pass, timeout}), 32'h0);
        check("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                 M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        check("rst_first_err", 32'(first_err_addr), 32'h0);
        check("rst_awaddr", 32'(M_AXI_AWADDR), 32'h0);
        check("rst_wdata", M_AXI_WDATA, 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Zero-wait run
        aw_base = aw_count;
        w_base  = w_count;
        start_run();
        check("t1_awvalid_wvalid", 32'({M_AXI_AWVALID, M_AXI_WVALID, busy}), 32'h7);
        check("t1_wstrb", 32'(M_AXI_WSTRB), 32'hF);
        wait_done(cycles);
        check("t1_done_cycle", 32'(cycles), 32'd17);
        check("t1_pass", 32'({pass, timeout, busy}), 32'h4);
        check("t1_err_count", 32'(err_count), 32'h0);
        check("t1_aw_count", 32'(aw_count - aw_base), 32'd4);
        check("t1_addr0", wr_addr_log[aw_base], 32'h0);
        check("t1_addr3", wr_addr_log[aw_base + 3], 32'hC);
        check("t1_data0", wr_data_log[w_base], 32'hA5A5_A5A5);
        check("t1_data1", wr_data_log[w_base + 1], 32'hA5A5_A5A1);
        check("t1_data2", wr_data_log[w_base + 2], 32'hA5A5_A5AD);
        check("t1_data3", wr_data_log[w_base + 3], 32'hA5A5_A5A9);
        repeat (3) @(posedge ACLK);
        #1;
        check("t1_done_sticky", 32'({done, pass}), 32'h3);

        // AW accepted 3 cycles before W
        w_delay = 3;
        aw_base = aw_count;
        w_base  = w_count;
        start_run();
        wait_done(cycles);
        check("t2_done_cycle", 32'(cycles), 32'd29);
        check("t2_aw_count", 32'(aw_count - aw_base), 32'd4);
        check("t2_w_count", 32'(w_count - w_base), 32'd4);
        check("t2_pass", 32'({pass, timeout}), 32'h2);
        check("t2_err_count", 32'(err_count), 32'h0);
        check("t2_data2", wr_data_log[w_base + 2], 32'hA5A5_A5AD);
        w_delay = 0;

        // Corrupted read data at 0x8
        corrupt_en = 1'b1;
        start_run();
        wait_done(cycles);
        check("t3_err_count", 32'(err_count), 32'h1);
        check("t3_first_err", 32'(first_err_addr), 32'h8);
        check("t3_pass", 32'({done, pass}), 32'h2);
        corrupt_en = 1'b0;

        // SLVERR on the second write
        bresp_err_en = 1'b1;
        start_run();
        wait_done(cycles);
        check("t4_err_count", 32'(err_count), 32'h1);
        check("t4_first_err", 32'(first_err_addr), 32'h4);
        check("t4_pass", 32'({done, pass, timeout}), 32'h4);
        bresp_err_en = 1'b0;

        // ARREADY stuck low: watchdog fires after 16 cycles in RD_REQ
        ar_allow = 1'b0;
        start_run();
        wait_done(cycles);
        check("t5_done_cycle", 32'(cycles), 32'd25);
        check("t5_timeout", 32'({timeout, done, pass}), 32'h6);
        check("t5_valids", 32'({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID}), 32'h0);
        check("t5_err_count", 32'(err_count), 32'h0);
        ar_allow = 1'b1;

        // Reset pulse in WR_RESP, then a clean run
        start_run();
        @(posedge ACLK);
        #1;
        check("t6_in_wresp", 32'({M_AXI_BREADY, busy}), 32'h3);
        #2;
        ARESETN = 1'b0;
        #1;
        check("t6_rst_status", 32'({busy, done, pass, timeout}), 32'h0);
        check("t6_rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                    M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
        check("t6_rst_addr", 32'(M_AXI_AWADDR), 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        aw_base = aw_count;
        start_run();
        wait_done(cycles);
        check("t6_done_cycle", 32'(cycles), 32'd17);
        check("t6_pass", 32'({pass, timeout}), 32'h2);
        check("t6_err_count", 32'(err_count), 32'h0);
        check("t6_aw_count", 32'(aw_count - aw_base), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
